// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the 19-bit pipeline register file.
package regfile_pkg;

   typedef enum logic {
      RF_IDLE,
      RF_CLEAR
   } rf_state_t;

   localparam int unsigned RF_DATA_W   = 19;
   localparam int unsigned RF_ADDR_W   = 5;
   localparam int unsigned RF_NUM_REGS = 20;

   localparam int unsigned REG_L0 = 0;
   localparam int unsigned REG_PC = 19;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index once, one per cycle, after a start pulse.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              busy_o,
   output logic              clr_en_o,
   output logic [ADDR_W-1:0] clr_idx_o,
   output logic              clr_done_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done    = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (start_i) begin
               state_d = RF_CLEAR;
               idx_d   = '0;
            end
         end
         RF_CLEAR: begin
            if (idx_q == LAST_IDX) begin
               done    = 1'b1;
               state_d = RF_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   assign busy_o     = (state_q == RF_CLEAR);
   assign clr_en_o   = (state_q == RF_CLEAR);
   assign clr_idx_o  = idx_q;
   assign clr_done_o = done;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async read ports with optional write bypass, two
// write ports with protection/range checking, sticky error flag, sequenced clear.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned         DATA_W    = RF_DATA_W,
   parameter int unsigned         NUM_REGS  = RF_NUM_REGS,
   parameter int unsigned         ADDR_W    = RF_ADDR_W,
   parameter int unsigned         NUM_RD    = 2,
   parameter logic [NUM_REGS-1:0] PROT_MASK = NUM_REGS'((1 << REG_PC) | (1 << REG_L0)),
   parameter bit                  BYPASS    = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     init_req,
   output logic                     busy,
   output logic                     wr_err
);

   localparam int unsigned          ADDR_SPAN = 2 ** ADDR_W;
   localparam logic [ADDR_SPAN-1:0] PROT_EXT  = ADDR_SPAN'(PROT_MASK);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];
   logic              wr_err_q, wr_err_d;
   logic              busy_w, clr_en, clr_done;
   logic [ADDR_W-1:0] clr_idx;
   logic              ok0, ok1, commit0, commit1, bad_wr;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (32'(a) < NUM_REGS) && !PROT_EXT[a];
   endfunction

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (reset),
      .start_i    (init_req),
      .busy_o     (busy_w),
      .clr_en_o   (clr_en),
      .clr_idx_o  (clr_idx),
      .clr_done_o (clr_done)
   );

   assign ok0     = addr_ok(wa0);
   assign ok1     = addr_ok(wa1);
   assign commit0 = we0 && ok0 && !busy_w;
   assign commit1 = we1 && ok1 && !busy_w;
   assign bad_wr  = !busy_w && ((we0 && !ok0) || (we1 && !ok1));

   // Port 1 is applied after port 0 so it wins on an address collision.
   always_comb begin
      mem_d    = mem_q;
      wr_err_d = wr_err_q;
      if (clr_en) begin
         mem_d[clr_idx] = '0;
         if (clr_done) wr_err_d = 1'b0;
      end else begin
         if (commit0) mem_d[wa0] = wd0;
         if (commit1) mem_d[wa1] = wd1;
         if (bad_wr)  wr_err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_err_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_err_q <= wr_err_d;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;

      assign addr = ra[k*ADDR_W +: ADDR_W];

      always_comb begin
         val = '0;
         if (!reset && !busy_w && (32'(addr) < NUM_REGS)) begin
            val = mem_q[addr];
            if (BYPASS && commit1 && (wa1 == addr))      val = wd1;
            else if (BYPASS && commit0 && (wa0 == addr)) val = wd0;
         end
      end

      assign rd[k*DATA_W +: DATA_W] = val;
   end

   assign busy   = busy_w;
   assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (A) and a small 3-read-port, no-bypass
// instance (B), both checked every cycle against a behavioural model.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0;
   logic        we0 [2];
   logic        we1 [2];
   logic        init [2];
   logic [4:0]  wa0 [2];
   logic [4:0]  wa1 [2];
   logic [18:0] wd0 [2];
   logic [18:0] wd1 [2];
   logic [4:0]  ra  [2][3];

   logic [37:0] rd_a;
   logic [56:0] rd_b;
   logic        busy_a, busy_b, err_a, err_b;

   int n_vec = 0;
   int n_err = 0;

   regfile_mp u_a (
      .clk      (clk),
      .reset    (reset),
      .ra       ({ra[0][1], ra[0][0]}),
      .rd       (rd_a),
      .we0      (we0[0]),
      .wa0      (wa0[0]),
      .wd0      (wd0[0]),
      .we1      (we1[0]),
      .wa1      (wa1[0]),
      .wd1      (wd1[0]),
      .init_req (init[0]),
      .busy     (busy_a),
      .wr_err   (err_a)
   );

   regfile_mp #(
      .DATA_W    (19),
      .NUM_REGS  (8),
      .ADDR_W    (3),
      .NUM_RD    (3),
      .PROT_MASK (8'h01),
      .BYPASS    (1'b0)
   ) u_b (
      .clk      (clk),
      .reset    (reset),
      .ra       ({ra[1][2][2:0], ra[1][1][2:0], ra[1][0][2:0]}),
      .rd       (rd_b),
      .we0      (we0[1]),
      .wa0      (wa0[1][2:0]),
      .wd0      (wd0[1]),
      .we1      (we1[1]),
      .wa1      (wa1[1][2:0]),
      .wd1      (wd1[1]),
      .init_req (init[1]),
      .busy     (busy_b),
      .wr_err   (err_b)
   );

   // ---------------- behavioural model ----------------
   logic [18:0] m_reg [2][32];
   int          m_left [2];
   logic        m_err [2];

   function automatic int nreg(input int i);   return (i == 0) ? 20 : 8; endfunction
   function automatic int nrd(input int i);    return (i == 0) ? 2 : 3;  endfunction
   function automatic bit byp(input int i);    return (i == 0);          endfunction
   function automatic logic [31:0] prot(input int i);
      return (i == 0) ? 32'h0008_0001 : 32'h0000_0001;
   endfunction
   function automatic logic [4:0] am(input int i, input logic [4:0] a);
      return (i == 0) ? a : {2'b00, a[2:0]};
   endfunction
   function automatic bit ok_m(input int i, input logic [4:0] a);
      logic [4:0]  m;
      logic [31:0] p;
      m = am(i, a);
      p = prot(i);
      return (int'(m) < nreg(i)) && !p[m];
   endfunction

   function automatic logic [18:0] model_rd(input int i, input int k);
      logic [4:0] a;
      a = am(i, ra[i][k]);
      if (reset || m_left[i] > 0 || int'(a) >= nreg(i)) return '0;
      if (byp(i) && we1[i] && ok_m(i, wa1[i]) && am(i, wa1[i]) == a) return wd1[i];
      if (byp(i) && we0[i] && ok_m(i, wa0[i]) && am(i, wa0[i]) == a) return wd0[i];
      return m_reg[i][a];
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            for (int r = 0; r < 32; r++) m_reg[i][r] <= '0;
            m_left[i] <= 0;
            m_err[i]  <= 1'b0;
         end else if (m_left[i] > 0) begin
            m_left[i] <= m_left[i] - 1;
            if (m_left[i] == 1) begin
               for (int r = 0; r < 32; r++) m_reg[i][r] <= '0;
               m_err[i] <= 1'b0;
            end
         end else begin
            if (we0[i] && ok_m(i, wa0[i])) m_reg[i][am(i, wa0[i])] <= wd0[i];
            if (we1[i] && ok_m(i, wa1[i])) m_reg[i][am(i, wa1[i])] <= wd1[i];
            if ((we0[i] && !ok_m(i, wa0[i])) || (we1[i] && !ok_m(i, wa1[i]))) m_err[i] <= 1'b1;
            if (init[i]) m_left[i] <= nreg(i);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] rdA(input int k); return rd_a[k*19 +: 19]; endfunction
   function automatic logic [18:0] rdB(input int k); return rd_b[k*19 +: 19]; endfunction

   always @(negedge clk) begin
      chk("busyA", 19'(busy_a), 19'(m_left[0] > 0));
      chk("busyB", 19'(busy_b), 19'(m_left[1] > 0));
      chk("errA",  19'(err_a),  19'(m_err[0]));
      chk("errB",  19'(err_b),  19'(m_err[1]));
      for (int k = 0; k < nrd(0); k++) chk($sformatf("rdA%0d", k), rdA(k), model_rd(0, k));
      for (int k = 0; k < nrd(1); k++) chk($sformatf("rdB%0d", k), rdB(k), model_rd(1, k));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_wr(input int i);
      we0[i]  = 1'b0;
      we1[i]  = 1'b0;
      init[i] = 1'b0;
   endtask

   task automatic count_busy(input int i, output int cnt);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if ((i == 0 ? busy_a : busy_b) == 1'b0) break;
         cnt++;
         step();
      end
      #1;
      no_wr(i);
   endtask

   int cnt;

   initial begin
      for (int i = 0; i < 2; i++) begin
         no_wr(i);
         wa0[i] = '0; wa1[i] = '0; wd0[i] = '0; wd1[i] = '0;
         for (int k = 0; k < 3; k++) ra[i][k] = '0;
      end
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_reset_rd0", rdA(0), 19'h0);
      chk("t1_reset_rd1", rdA(1), 19'h0);
      chk("t1_reset_busy", 19'(busy_a), 19'h0);
      chk("t1_reset_err", 19'(err_a), 19'h0);
      step();
      reset = 1'b0;

      // 1: bypass then stored
      we0[0] = 1'b1; wa0[0] = 5'd5; wd0[0] = 19'h1ABCD; ra[0][0] = 5'd5;
      @(negedge clk); chk("t1_bypass", rdA(0), 19'h1ABCD);
      step(); no_wr(0);
      @(negedge clk); chk("t1_stored", rdA(0), 19'h1ABCD);

      // 2: write-port collision and dual write
      step();
      we0[0] = 1'b1; wa0[0] = 5'd3; wd0[0] = 19'h00011;
      we1[0] = 1'b1; wa1[0] = 5'd3; wd1[0] = 19'h00022; ra[0][0] = 5'd3;
      step(); no_wr(0);
      @(negedge clk); chk("t2_same_addr", rdA(0), 19'h00022);
      step();
      we0[0] = 1'b1; wa0[0] = 5'd3; wd0[0] = 19'h00011;
      we1[0] = 1'b1; wa1[0] = 5'd4; wd1[0] = 19'h00022; ra[0][1] = 5'd4;
      step(); no_wr(0);
      @(negedge clk);
      chk("t2_reg3", rdA(0), 19'h00011);
      chk("t2_reg4", rdA(1), 19'h00022);

      // 3: protected and out-of-range writes
      step();
      we0[0] = 1'b1; wa0[0] = 5'd0; wd0[0] = 19'h7FFFF; ra[0][0] = 5'd0;
      @(negedge clk);
      chk("t3_l0_nobypass", rdA(0), 19'h0);
      chk("t3_err_before", 19'(err_a), 19'h0);
      step(); no_wr(0);
      @(negedge clk);
      chk("t3_l0_read", rdA(0), 19'h0);
      chk("t3_err_set", 19'(err_a), 19'h1);
      step();
      we0[0] = 1'b1; wa0[0] = 5'd19; wd0[0] = 19'h12345; ra[0][0] = 5'd19;
      step(); no_wr(0);
      @(negedge clk); chk("t3_pc_read", rdA(0), 19'h0);
      step();
      we0[0] = 1'b1; wa0[0] = 5'd25; wd0[0] = 19'h54321; ra[0][0] = 5'd25;
      @(negedge clk); chk("t3_oor_read", rdA(0), 19'h0);
      step(); no_wr(0); ra[0][0] = 5'd5;
      @(negedge clk);
      chk("t3_err_held", 19'(err_a), 19'h1);
      chk("t3_reg5_kept", rdA(0), 19'h1ABCD);

      // 4: fill, then clear while writes are attempted
      for (int i = 1; i <= 18; i++) begin
         step();
         we0[0] = 1'b1; wa0[0] = 5'(i); wd0[0] = 19'(i);
      end
      step(); no_wr(0); ra[0][0] = 5'd18; ra[0][1] = 5'd1;
      @(negedge clk);
      chk("t4_reg18", rdA(0), 19'd18);
      chk("t4_reg1", rdA(1), 19'd1);
      step();
      init[0] = 1'b1;
      step(); init[0] = 1'b0;
      we0[0] = 1'b1; wa0[0] = 5'd7;  wd0[0] = 19'h00077; ra[0][0] = 5'd7;
      we1[0] = 1'b1; wa1[0] = 5'd19; wd1[0] = 19'h00001;
      count_busy(0, cnt);
      chk("t4_busy_len", 19'(cnt), 19'd20);
      chk("t4_err_cleared", 19'(err_a), 19'h0);
      for (int r = 0; r < 20; r++) begin
         ra[0][0] = 5'(r); ra[0][1] = 5'(19 - r);
         @(negedge clk); chk($sformatf("t4_zero%0d", r), rdA(0), 19'h0);
         step();
      end

      // 5: reset in the 7th clear cycle
      we0[0] = 1'b1; wa0[0] = 5'd3; wd0[0] = 19'h00009; ra[0][0] = 5'd3;
      step(); no_wr(0);
      init[0] = 1'b1;
      step(); init[0] = 1'b0;
      repeat (6) step();
      chk("t5_busy_pre", 19'(busy_a), 19'h1);
      reset = 1'b1;
      #1;
      chk("t5_busy_now", 19'(busy_a), 19'h0);
      chk("t5_rd_now", rdA(0), 19'h0);
      step();
      reset = 1'b0;
      @(negedge clk); chk("t5_reg3_zero", rdA(0), 19'h0);
      step();
      we0[0] = 1'b1; wa0[0] = 5'd2; wd0[0] = 19'h00005;
      step(); no_wr(0); ra[0][0] = 5'd2;
      @(negedge clk); chk("t5_reg2", rdA(0), 19'h00005);

      // 6: small instance, no bypass, three read ports
      step();
      we0[1] = 1'b1; wa0[1] = 5'd2; wd0[1] = 19'h00123; ra[1][0] = 5'd2;
      @(negedge clk); chk("t6_nobypass", rdB(0), 19'h0);
      step(); no_wr(1);
      @(negedge clk); chk("t6_reg2", rdB(0), 19'h00123);
      step();
      we0[1] = 1'b1; wa0[1] = 5'd7; wd0[1] = 19'h00077;
      we1[1] = 1'b1; wa1[1] = 5'd5; wd1[1] = 19'h00055;
      ra[1][1] = 5'd5; ra[1][2] = 5'd7;
      @(negedge clk);
      chk("t6_old5", rdB(1), 19'h0);
      chk("t6_old7", rdB(2), 19'h0);
      step(); no_wr(1);
      @(negedge clk);
      chk("t6_p0", rdB(0), 19'h00123);
      chk("t6_p1", rdB(1), 19'h00055);
      chk("t6_p2", rdB(2), 19'h00077);
      step();
      we0[1] = 1'b1; wa0[1] = 5'd0; wd0[1] = 19'h00001; ra[1][0] = 5'd0;
      step(); no_wr(1);
      @(negedge clk);
      chk("t6_reg0", rdB(0), 19'h0);
      chk("t6_err", 19'(err_b), 19'h1);
      step();
      init[1] = 1'b1;
      step(); init[1] = 1'b0;
      count_busy(1, cnt);
      chk("t6_busy_len", 19'(cnt), 19'd8);
      chk("t6_err_cleared", 19'(err_b), 19'h0);
      @(negedge clk);
      chk("t6_cleared7", rdB(2), 19'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
